// File: rtl/pc_adder_pkg.sv
// Shared constants and types for PC arithmetic: address width, sequential
// step size and the default reset vector.
package pc_adder_pkg;

  localparam int XLEN = 32;
  localparam int PC_STEP = 4;
  localparam logic [XLEN-1:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

  typedef logic [XLEN-1:0] addr_t;

endpackage

// File: rtl/pc_adder_pc_add.sv
// XLEN-bit modulo adder; the carry-out is dropped so address wrap-around
// is legal and silent.
module pc_add #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/pc_adder.sv
// Next-PC arithmetic and the fetch PC register: computes PC+4 and PC+imm,
// selects the next PC, flags misaligned targets and registers the result.
module pc_adder #(
  parameter int XLEN = pc_adder_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(pc_adder_pkg::RESET_VECTOR_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] pc_current,
  input  logic [XLEN-1:0] imm,
  input  logic            take_branch,
  input  logic            pc_en,
  output logic [XLEN-1:0] pc_plus_4,
  output logic [XLEN-1:0] pc_branch,
  output logic [XLEN-1:0] pc_next,
  output logic [XLEN-1:0] pc_q,
  output logic            target_misaligned
);

  import pc_adder_pkg::*;

  localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

  pc_add #(.W(XLEN)) u_add_seq (
    .a   (pc_current),
    .b   (STEP),
    .sum (pc_plus_4)
  );

  pc_add #(.W(XLEN)) u_add_branch (
    .a   (pc_current),
    .b   (imm),
    .sum (pc_branch)
  );

  // The target is passed through unmodified even when misaligned; the
  // control unit decides whether to trap.
  always_comb begin
    pc_next           = take_branch ? pc_branch : pc_plus_4;
    target_misaligned = take_branch & (pc_branch[1:0] != 2'b00);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_VECTOR;
    end else if (pc_en) begin
      pc_q <= pc_next;
    end
  end

endmodule

// File: tb/tb_pc_adder.sv
// Scoreboard bench for pc_adder: directed test-plan vectors then random
// traffic, checked against an arithmetic reference model.
module tb_pc_adder;

  import pc_adder_pkg::*;

  localparam logic [31:0] RV = 32'h8000_0000;

  typedef struct {
    logic [31:0] plus4;
    logic [31:0] branch;
    logic [31:0] next;
    logic [31:0] q;
    logic        mis;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_current;
  logic [31:0] imm;
  logic        take_branch;
  logic        pc_en;
  logic [31:0] pc_plus_4;
  logic [31:0] pc_branch;
  logic [31:0] pc_next;
  logic [31:0] pc_q;
  logic        target_misaligned;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] model_pc;

  pc_adder #(.XLEN(32), .RESET_VECTOR(RV)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .pc_current        (pc_current),
    .imm               (imm),
    .take_branch       (take_branch),
    .pc_en             (pc_en),
    .pc_plus_4         (pc_plus_4),
    .pc_branch         (pc_branch),
    .pc_next           (pc_next),
    .pc_q              (pc_q),
    .target_misaligned (target_misaligned)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (pc=0x%08h imm=0x%08h br=%0b en=%0b rst_n=%0b)",
               name, act, exp, pc_current, imm, take_branch, pc_en, rst_n);
    end
  endtask

  // Reference model: plain modulo-2^32 arithmetic on wide integers.
  task automatic apply_stimulus(input logic [31:0] pc, input logic [31:0] off,
                                input logic br, input logic en, input logic rst);
    exp_t        e;
    longint      p4;
    longint      pb;
    @(negedge clk);
    pc_current  = pc;
    imm         = off;
    take_branch = br;
    pc_en       = en;
    rst_n       = rst;
    #1;
    p4 = (longint'(pc) + 64'd4) % 64'h1_0000_0000;
    pb = (longint'(pc) + longint'(off)) % 64'h1_0000_0000;
    e.plus4  = 32'(p4);
    e.branch = 32'(pb);
    e.next   = br ? 32'(pb) : 32'(p4);
    e.mis    = br && ((pb % 4) != 0);
    if (!rst) model_pc = RV;
    e.q = model_pc;
    sb.push_back(e);
    if (rst && en) model_pc = e.next;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      wait (sb.size() != 0);
      e = sb.pop_front();
      check_output("pc_plus_4", pc_plus_4, e.plus4);
      check_output("pc_branch", pc_branch, e.branch);
      check_output("pc_next", pc_next, e.next);
      check_output("pc_q", pc_q, e.q);
      check_output("target_misaligned", {31'd0, target_misaligned}, {31'd0, e.mis});
    end
  end

  initial begin : stimulus
    logic [31:0] r_pc;
    logic [31:0] r_imm;
    int          waited;
    model_pc    = RV;
    rst_n       = 1'b0;
    pc_current  = '0;
    imm         = '0;
    take_branch = 1'b0;
    pc_en       = 1'b0;

    // Reset held low while the arithmetic vectors from the test plan run.
    apply_stimulus(32'h0000_0000, 32'h0000_0010, 1'b0, 1'b1, 1'b0);
    apply_stimulus(32'h0000_0020, 32'hFFFF_FFF0, 1'b1, 1'b1, 1'b0);
    apply_stimulus(32'h0000_0040, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
    apply_stimulus(32'h1000_0000, 32'h0000_1000, 1'b1, 1'b1, 1'b0);
    apply_stimulus(32'hFFFF_FFFC, 32'h0000_0008, 1'b0, 1'b1, 1'b0);
    apply_stimulus(32'h0000_0100, 32'h0000_0002, 1'b1, 1'b1, 1'b0);

    // Register sequencing: load 0xC, hold, then reset mid-run.
    apply_stimulus(32'h0000_0008, 32'h0000_0000, 1'b0, 1'b1, 1'b1);
    apply_stimulus(32'h0000_0300, 32'h0000_0004, 1'b0, 1'b0, 1'b1);
    apply_stimulus(32'h0000_0400, 32'h0000_0008, 1'b1, 1'b0, 1'b1);
    apply_stimulus(32'h0000_0500, 32'h0000_0010, 1'b1, 1'b1, 1'b1);
    apply_stimulus(32'h0000_0600, 32'h0000_0020, 1'b0, 1'b1, 1'b0);
    apply_stimulus(32'h0000_0700, 32'h0000_0003, 1'b1, 1'b1, 1'b1);

    for (int i = 0; i < 300; i++) begin
      r_pc  = $urandom();
      r_imm = $urandom();
      if ($urandom_range(0, 3) == 0) r_pc = {r_pc[31:2], 2'b00} | 32'hFFFF_FF00;
      if ($urandom_range(0, 2) == 0) r_imm = {r_imm[31:2], 2'b00};
      apply_stimulus(r_pc, r_imm, 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 3) != 0),
                     1'($urandom_range(0, 19) != 0));
    end

    waited = 0;
    while (sb.size() != 0 && waited < 100) begin
      #1;
      waited++;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
